// File: rtl/seg_scan_mux.sv
// Four-digit multiplexed seven-segment scanner with frame-aligned shadow capture.
// Each digit slot is DIV cycles: DIV-1 lit cycles followed by one dark anti-ghost cycle.
module seg_scan_mux #(
    parameter int DIV = 50000
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [6:0] D0,
    input  logic [6:0] D1,
    input  logic [6:0] D2,
    input  logic [6:0] D3,
    input  logic       LOAD,
    input  logic       BLANK,
    output logic [6:0] SEG,
    output logic [3:0] AN,
    output logic       LOAD_ACK,
    output logic       FRAME
);

    localparam int CW = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    idx_q, idx_d;
    logic          pend_q, pend_d;
    logic [6:0]    shadow_q [4];
    logic [6:0]    shadow_d [4];
    logic [6:0]    seg_q, seg_d;
    logic [3:0]    an_q, an_d;
    logic          ack_q, ack_d;
    logic          frame_q, frame_d;

    logic tick;
    logic boundary;
    logic capture;

    always_comb begin
        tick     = (cnt_q == CNT_LAST);
        boundary = tick && (idx_q == 2'd3);
        capture  = boundary && (pend_q || LOAD);

        cnt_d  = tick ? '0 : cnt_q + 1'b1;
        idx_d  = tick ? idx_q + 2'd1 : idx_q;
        pend_d = boundary ? 1'b0 : (pend_q | LOAD);

        shadow_d = shadow_q;
        if (capture) begin
            shadow_d[0] = D0;
            shadow_d[1] = D1;
            shadow_d[2] = D2;
            shadow_d[3] = D3;
        end

        // The last cycle of every slot is forced dark so the enable switch never ghosts.
        if (BLANK || tick) begin
            an_d  = 4'b1111;
            seg_d = 7'b1111111;
        end else begin
            an_d  = ~(4'b0001 << idx_q);
            seg_d = shadow_q[idx_q];
        end

        ack_d   = capture;
        frame_d = boundary;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt_q    <= '0;
            idx_q    <= 2'd0;
            pend_q   <= 1'b0;
            shadow_q <= '{default: 7'b1111111};
            seg_q    <= 7'b1111111;
            an_q     <= 4'b1111;
            ack_q    <= 1'b0;
            frame_q  <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            pend_q   <= pend_d;
            shadow_q <= shadow_d;
            seg_q    <= seg_d;
            an_q     <= an_d;
            ack_q    <= ack_d;
            frame_q  <= frame_d;
        end
    end

    assign SEG      = seg_q;
    assign AN       = an_q;
    assign LOAD_ACK = ack_q;
    assign FRAME    = frame_q;

endmodule

// File: tb/tb_seg_scan_mux.sv
// Bench for seg_scan_mux with DIV=4: a time-indexed behavioural model checked every
// cycle, plus directed scenarios with hand-computed literal expectations.
module tb_seg_scan_mux;

    localparam int DIV = 4;

    logic       CLK;
    logic       RST;
    logic [6:0] D0, D1, D2, D3;
    logic       LOAD, BLANK;
    logic [6:0] SEG;
    logic [3:0] AN;
    logic       LOAD_ACK, FRAME;

    int n_tests = 0;
    int n_fail  = 0;

    seg_scan_mux #(.DIV(DIV)) dut (
        .CLK(CLK), .RST(RST),
        .D0(D0), .D1(D1), .D2(D2), .D3(D3),
        .LOAD(LOAD), .BLANK(BLANK),
        .SEG(SEG), .AN(AN), .LOAD_ACK(LOAD_ACK), .FRAME(FRAME)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at t=%0d: got %0h, expected %0h", name, m_t, act, exp);
        end
    endtask

    // Model: m_t is the index of the current cycle since reset release.
    int         m_t = 0;
    bit         m_valid = 0;
    bit         m_pend;
    logic [6:0] m_shadow [4];
    logic [3:0] an_of [4] = '{4'hE, 4'hD, 4'hB, 4'h7};
    logic [6:0] e_seg;
    logic [3:0] e_an;
    logic       e_ack, e_frame;

    always @(posedge CLK) begin
        int  slot_pos, digit;
        bit  last_of_slot, frame_end;
        m_valid = 1;
        if (RST) begin
            m_t = 0;
            m_pend = 0;
            for (int k = 0; k < 4; k++) m_shadow[k] = 7'h7F;
            e_seg = 7'h7F; e_an = 4'hF; e_ack = 0; e_frame = 0;
        end else begin
            slot_pos     = m_t % DIV;
            digit        = (m_t / DIV) % 4;
            last_of_slot = (slot_pos == DIV - 1);
            frame_end    = last_of_slot && (digit == 3);
            if (BLANK || last_of_slot) begin
                e_an = 4'hF; e_seg = 7'h7F;
            end else begin
                e_an = an_of[digit]; e_seg = m_shadow[digit];
            end
            e_ack   = frame_end && (m_pend || LOAD);
            e_frame = frame_end;
            if (e_ack) begin
                m_shadow[0] = D0; m_shadow[1] = D1; m_shadow[2] = D2; m_shadow[3] = D3;
            end
            m_pend = frame_end ? 0 : (m_pend || LOAD);
            m_t++;
        end
    end

    always @(negedge CLK) begin
        if (m_valid) begin
            chk("model_seg",   32'(SEG),      32'(e_seg));
            chk("model_an",    32'(AN),       32'(e_an));
            chk("model_ack",   32'(LOAD_ACK), 32'(e_ack));
            chk("model_frame", 32'(FRAME),    32'(e_frame));
        end
    end

    task automatic goto_t(input int target);
        for (int i = 0; i < 300 && m_t != target; i++) @(negedge CLK);
        chk("goto", 32'(m_t), 32'(target));
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    logic [3:0] an_tab [16] = '{4'hE, 4'hE, 4'hE, 4'hF, 4'hD, 4'hD, 4'hD, 4'hF,
                                4'hB, 4'hB, 4'hB, 4'hF, 4'h7, 4'h7, 4'h7, 4'hF};
    logic [6:0] seg_tab [4] = '{7'h40, 7'h79, 7'h24, 7'h30};

    initial begin
        int acks, ack_t;
        RST = 1; LOAD = 1; BLANK = 0;
        D0 = 7'h00; D1 = 7'h00; D2 = 7'h00; D3 = 7'h00;

        // reset held 3 cycles with LOAD high
        @(posedge CLK);
        repeat (3) begin
            @(negedge CLK);
            chk("rst_seg",   32'(SEG),      32'h7F);
            chk("rst_an",    32'(AN),       32'hF);
            chk("rst_ack",   32'(LOAD_ACK), 32'h0);
            chk("rst_frame", 32'(FRAME),    32'h0);
        end
        RST = 0; LOAD = 0;
        for (int i = 1; i <= 3; i++) begin
            @(negedge CLK);
            chk("rel_an",  32'(AN),  32'hE);
            chk("rel_seg", 32'(SEG), 32'h7F);
        end

        // scan order
        D0 = 7'h40; D1 = 7'h79; D2 = 7'h24; D3 = 7'h30; LOAD = 1;
        @(negedge CLK); LOAD = 0;
        goto_t(16);
        chk("scan_ack",   32'(LOAD_ACK), 32'h1);
        chk("scan_frame", 32'(FRAME),    32'h1);
        chk("scan_dead",  32'(AN),       32'hF);
        for (int i = 0; i < 16; i++) begin
            @(negedge CLK);
            chk("scan_an", 32'(AN), 32'(an_tab[i]));
            if (an_tab[i] != 4'hF) chk("scan_seg", 32'(SEG), 32'(seg_tab[i / 4]));
            if (i == 15) chk("scan_frame2", 32'(FRAME), 32'h1);
        end

        // mid-frame double LOAD, then D0 change before the boundary
        goto_t(36);
        LOAD = 1; @(negedge CLK); LOAD = 0;
        @(negedge CLK); LOAD = 1; @(negedge CLK); LOAD = 0;
        @(negedge CLK); D0 = 7'h12;
        acks = 0; ack_t = -1;
        for (int i = 0; i < 20; i++) begin
            @(negedge CLK);
            if (LOAD_ACK) begin acks++; ack_t = m_t; end
            if (m_t == 45) chk("mid_old_seg", 32'(SEG), 32'h30);
            if (m_t == 49) begin
                chk("mid_new_seg", 32'(SEG), 32'h12);
                chk("mid_new_an",  32'(AN),  32'hE);
            end
        end
        chk("mid_ack_count", 32'(acks),  32'd1);
        chk("mid_ack_time",  32'(ack_t), 32'd48);

        // LOAD only on the boundary cycle
        goto_t(61);
        D0 = 7'h01; D1 = 7'h02; D2 = 7'h03; D3 = 7'h04;
        goto_t(63); LOAD = 1;
        @(negedge CLK); LOAD = 0;
        chk("bnd_ack",   32'(LOAD_ACK), 32'h1);
        chk("bnd_frame", 32'(FRAME),    32'h1);
        @(negedge CLK);
        chk("bnd_seg", 32'(SEG), 32'h01);
        chk("bnd_an",  32'(AN),  32'hE);

        // BLANK during idx=2, capture continues underneath
        goto_t(72); BLANK = 1;
        @(negedge CLK);
        chk("blk_seg", 32'(SEG), 32'h7F);
        chk("blk_an",  32'(AN),  32'hF);
        goto_t(76);
        D0 = 7'h11; D1 = 7'h22; D2 = 7'h33; D3 = 7'h44; LOAD = 1;
        @(negedge CLK); LOAD = 0;
        goto_t(80);
        chk("blk_frame", 32'(FRAME),    32'h1);
        chk("blk_ack",   32'(LOAD_ACK), 32'h1);
        chk("blk_dark",  32'(AN),       32'hF);
        goto_t(85); BLANK = 0;
        @(negedge CLK);
        chk("unblk_an",  32'(AN),  32'hD);
        chk("unblk_seg", 32'(SEG), 32'h22);
        goto_t(96);
        chk("unblk_frame", 32'(FRAME), 32'h1);

        // reset mid-scan with a pending load
        goto_t(104); LOAD = 1;
        @(negedge CLK); LOAD = 0;
        @(negedge CLK); RST = 1;
        @(negedge CLK); RST = 0;
        chk("mrst_t", 32'(m_t), 32'd0);
        acks = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge CLK);
            if (LOAD_ACK) acks++;
            if (m_t >= 1 && m_t <= 3) begin
                chk("mrst_an",  32'(AN),  32'hE);
                chk("mrst_seg", 32'(SEG), 32'h7F);
            end
            if (m_t == 16) chk("mrst_frame", 32'(FRAME), 32'h1);
            if (m_t == 17) chk("mrst_blank_shadow", 32'(SEG), 32'h7F);
        end
        chk("mrst_no_ack", 32'(acks), 32'd0);

        repeat (2) @(negedge CLK);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
